mbist_checker: RTL

MBIST_CHECKER -- requirements
Module: mbist_checker

---
 rtl/mbist_pkg.sv | 32 +++
 rtl/mbist_checker_if.sv | 33 +++
 rtl/mbist_pattern_gen.sv | 45 ++++
 rtl/mbist_checker.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mbist_pkg
// Description : Shared MBIST constants: data patterns, FSM encoding, defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package mbist_pkg;

    localparam int DEF_DATA_W = 56;
    localparam int DEF_ADDR_W = 9;

    localparam logic [55:0] c_pat_zero = 56'h00_0000_0000_0000;
    localparam logic [55:0] c_pat_ones = 56'hFF_FFFF_FFFF_FFFF;
    localparam logic [55:0] c_pat_55   = 56'h55_5555_5555_5555;
    localparam logic [55:0] c_pat_aa   = 56'hAA_AAAA_AAAA_AAAA;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_ONES = 2'd1,
        SEL_55   = 2'd2,
        SEL_AA   = 2'd3
    } pat_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : mbist_pkg
`default_nettype wire

// File: rtl/mbist_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : mbist_checker_if
// Description : Memory read port between the MBIST checker and the array.
// Revision    : 1.0 - initial release
// ============================================================================
interface mbist_checker_if #(
    parameter int DATA_W = 56,
    parameter int ADDR_W = 9
);
    logic [DATA_W-1:0] mem_do;
    logic [ADDR_W-4:0] mem_ra;
    logic [2:0]        mem_ca;
    logic              mem_nce;
    logic              mem_nwrt;

    modport master (
        input  mem_do,
        output mem_ra,
        output mem_ca,
        output mem_nce,
        output mem_nwrt
    );

    modport slave (
        output mem_do,
        input  mem_ra,
        input  mem_ca,
        input  mem_nce,
        input  mem_nwrt
    );
endinterface : mbist_checker_if
`default_nettype wire

// File: rtl/mbist_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : mbist_pattern_gen
// Description : Combinational 2-bit select to full-width MBIST data pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_pattern_gen
    import mbist_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic [1:0]        i_sel,
    output logic      [DATA_W-1:0] o_pattern
);

    generate
        if (DATA_W == 56) begin : g_native
            always_comb begin
                o_pattern = c_pat_zero;
                case (i_sel)
                    SEL_ZERO: o_pattern = c_pat_zero;
                    SEL_ONES: o_pattern = c_pat_ones;
                    SEL_55:   o_pattern = c_pat_55;
                    SEL_AA:   o_pattern = c_pat_aa;
                    default:  o_pattern = c_pat_zero;
                endcase
            end
        end else begin : g_generic
            // Other widths: 55.. has even bits set, AA.. has odd bits set.
            always_comb begin
                o_pattern = '0;
                for (int i = 0; i < DATA_W; i++) begin
                    case (i_sel)
                        SEL_ONES: o_pattern[i] = 1'b1;
                        SEL_55:   o_pattern[i] = ~i[0];
                        SEL_AA:   o_pattern[i] = i[0];
                        default:  o_pattern[i] = 1'b0;
                    endcase
                end
            end
        end
    endgenerate

endmodule : mbist_pattern_gen
`default_nettype wire

// File: rtl/mbist_checker.sv
`default_nettype none
// ============================================================================
// Module      : mbist_checker
// Description : MBIST read-back checker: sweeps all words, compares against a
//               selected pattern, counts errors and captures the first fail.
// Revision    : 1.0 - initial release
// ============================================================================
module mbist_checker
    import mbist_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mbist_checker_if.master        mem,
    input  wire logic              chk_start,
    input  wire logic [1:0]        pattern_sel,
    output logic                   chk_busy,
    output logic                   chk_done,
    output logic                   chk_pass,
    output logic [ADDR_W:0]        err_cnt,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [DATA_W-1:0]      fail_data
);

    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   c_err_max   = {(ADDR_W+1){1'b1}};

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_vld;
    logic                r_nce;
    logic                r_first_seen;
    logic [DATA_W-1:0]   r_pattern;
    logic [ADDR_W:0]     r_err_cnt;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_data;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic [DATA_W-1:0]   w_pattern;
    logic                w_mismatch;
    logic                w_start_ok;
    logic [ADDR_W:0]     w_err_nxt;

    mbist_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .i_sel     (pattern_sel),
        .o_pattern (w_pattern)
    );

    assign w_start_ok = chk_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_mismatch = r_rd_vld && (mem.mem_do != r_pattern);
    assign w_err_nxt  = (w_mismatch && (r_err_cnt != c_err_max)) ? r_err_cnt + 1'b1 : r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_rd_addr    <= '0;
            r_rd_vld     <= 1'b0;
            r_nce        <= 1'b1;
            r_first_seen <= 1'b0;
            r_pattern    <= '0;
            r_err_cnt    <= '0;
            r_fail_addr  <= '0;
            r_fail_data  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            // Read data returns one cycle after the address, so compare lags by one.
            r_rd_vld  <= (r_state == ST_READ);
            r_rd_addr <= r_addr;

            if (r_rd_vld) begin
                r_err_cnt <= w_err_nxt;
                if (w_mismatch && !r_first_seen) begin
                    r_first_seen <= 1'b1;
                    r_fail_addr  <= r_rd_addr;
                    r_fail_data  <= mem.mem_do;
                end
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state      <= ST_READ;
                        r_pattern    <= w_pattern;
                        r_addr       <= '0;
                        r_nce        <= 1'b0;
                        r_first_seen <= 1'b0;
                        r_err_cnt    <= '0;
                        r_fail_addr  <= '0;
                        r_fail_data  <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end
                ST_READ: begin
                    // Wraps to zero after the last word so IDLE/DONE drive address 0.
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == c_last_addr) begin
                        r_state <= ST_DRAIN;
                        r_nce   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_nxt == '0);
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_ra   = r_addr[ADDR_W-1:3];
    assign mem.mem_ca   = r_addr[2:0];
    assign mem.mem_nce  = r_nce;
    assign mem.mem_nwrt = 1'b1;

    assign chk_busy  = r_busy;
    assign chk_done  = r_done;
    assign chk_pass  = r_pass;
    assign err_cnt   = r_err_cnt;
    assign fail_addr = r_fail_addr;
    assign fail_data = r_fail_data;

endmodule : mbist_checker
`default_nettype wire
